stream_slice_packer: RTL and testbench

- Sequential stage that sits directly upstream of the stream-operator consumer logic.
- Collects DEPTH narrow input words, with the first-accepted word going into the MSBs.
- Applies a left-stream slice reorder, equivalent to {<< SLICE {w0, w1, ..., wN-1}}, and presents the result as one wide word.
- Uses valid/ready handshakes on both sides, supports a flush with zero padding, and holds the output stably under backpressure.

---
 rtl/stream_pack_pkg.sv | 18 +
 rtl/stream_slice_reverse.sv | 24 ++
 rtl/stream_slice_packer.sv | 139 +++++++++++++
 tb/tb_stream_slice_packer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pack_pkg.sv
// Shared definitions for the stream slice packer.
//   state_e       : packer control state (COLLECT gathers words, EMIT holds a packed word)
//   params_legal  : elaboration-time legality check for the packer parameters
package stream_pack_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  // DEPTH must be at least 2 so that the word accepted during an output
  // handshake can never complete a group on its own. SLICE must tile the
  // packed word exactly.
  function automatic bit params_legal(int in_w, int depth, int slice);
    return (depth >= 2) && (slice >= 1) && (((in_w * depth) % slice) == 0);
  endfunction

endpackage

// File: rtl/stream_slice_reverse.sv
// Combinational left-stream slice reorder: out = {<< SLICE {in}}.
// The input is cut into SLICE-bit slices starting at the MSB and the slice
// order is reversed; bits inside each slice keep their order.
//   in  [W-1:0] : word to reorder
//   out [W-1:0] : slice-reversed word
module stream_slice_reverse #(
  parameter int W     = 8,
  parameter int SLICE = 2
) (
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  localparam int N = W / SLICE;

  genvar gi;
  generate
    // Lowest output slice takes the highest input slice, and so on.
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign out[gi*SLICE +: SLICE] = in[(N-1-gi)*SLICE +: SLICE];
    end
  endgenerate

endmodule

// File: rtl/stream_slice_packer.sv
// Packs DEPTH narrow input words (first word in the MSBs) into one wide word,
// applies a SLICE-bit left-stream reorder and presents it downstream.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_data carries one IN_W word
//   flush                 : emit a partially filled group, zero padded
//   out_valid/out_ready   : output handshake
//   out_data              : reordered packed word (IN_W*DEPTH bits)
//   out_partial           : current output word was padded by a flush
module stream_slice_packer
  import stream_pack_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int DEPTH = 2,
  parameter int SLICE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_W*DEPTH-1:0] out_data,
  output logic                  out_partial
);

  localparam int OUT_W = IN_W * DEPTH;
  localparam int CNT_W = $clog2(DEPTH);

  generate
    if (!params_legal(IN_W, DEPTH, SLICE)) begin : g_bad_params
      $error("stream_slice_packer: illegal IN_W/DEPTH/SLICE combination");
    end
  endgenerate

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [OUT_W-1:0] buffer_reg, buffer_next;
  logic [OUT_W-1:0] out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_partial_reg, out_partial_next;

  logic             in_fire;
  logic             out_fire;
  logic [OUT_W-1:0] merged_buf;
  logic [OUT_W-1:0] merged_rev;

  assign in_ready = (state_reg == COLLECT) ? 1'b1 : out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_reg & out_ready;

  // Buffer as it would look with this cycle's word written into slot count.
  // Unfilled slots are always zero, which gives flush its padding for free.
  // In EMIT count is 0, so an accepted word lands in slot 0 of a new group.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign merged_buf[OUT_W-1-gi*IN_W -: IN_W] =
        (in_fire && (count_reg == CNT_W'(gi))) ? in_data
                                               : buffer_reg[OUT_W-1-gi*IN_W -: IN_W];
    end
  endgenerate

  stream_slice_reverse #(
    .W     (OUT_W),
    .SLICE (SLICE)
  ) u_reverse (
    .in  (merged_buf),
    .out (merged_rev)
  );

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    buffer_next      = buffer_reg;
    out_data_next    = out_data_reg;
    out_valid_next   = out_valid_reg;
    out_partial_next = out_partial_reg;

    case (state_reg)
      COLLECT: begin
        if (in_fire && (count_reg == CNT_W'(DEPTH-1))) begin
          // Group complete; a same-cycle flush is absorbed here.
          out_data_next    = merged_rev;
          out_valid_next   = 1'b1;
          out_partial_next = 1'b0;
          count_next       = '0;
          buffer_next      = '0;
          state_next       = EMIT;
        end else if (flush && (in_fire || (count_reg != '0))) begin
          out_data_next    = merged_rev;
          out_valid_next   = 1'b1;
          out_partial_next = 1'b1;
          count_next       = '0;
          buffer_next      = '0;
          state_next       = EMIT;
        end else if (in_fire) begin
          buffer_next = merged_buf;
          count_next  = count_reg + 1'b1;
        end
      end
      EMIT: begin
        if (out_fire) begin
          out_valid_next = 1'b0;
          state_next     = COLLECT;
          if (in_fire) begin
            buffer_next = merged_buf;
            count_next  = CNT_W'(1);
          end
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= COLLECT;
      count_reg       <= '0;
      buffer_reg      <= '0;
      out_data_reg    <= '0;
      out_valid_reg   <= 1'b0;
      out_partial_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      buffer_reg      <= buffer_next;
      out_data_reg    <= out_data_next;
      out_valid_reg   <= out_valid_next;
      out_partial_reg <= out_partial_next;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_partial = out_partial_reg;

endmodule

// File: tb/tb_stream_slice_packer.sv
module tb_stream_slice_packer;

  localparam int IN_W  = 4;
  localparam int DEPTH = 2;
  localparam int OUT_W = IN_W * DEPTH;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             flush;
  logic             out_ready;

  logic             in_ready, s1_in_ready;
  logic             out_valid, s1_out_valid;
  logic [OUT_W-1:0] out_data, s1_out_data;
  logic             out_partial, s1_out_partial;

  int n_pass;
  int n_total;

  stream_slice_packer #(.IN_W(IN_W), .DEPTH(DEPTH), .SLICE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_partial(out_partial)
  );

  stream_slice_packer #(.IN_W(IN_W), .DEPTH(DEPTH), .SLICE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_in_ready),
    .in_data(in_data), .flush(flush), .out_valid(s1_out_valid),
    .out_ready(out_ready), .out_data(s1_out_data), .out_partial(s1_out_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference reorder: take slices counted from the LSB and place slice k at
  // mirrored position n-1-k.
  function automatic logic [OUT_W-1:0] ref_rev(logic [OUT_W-1:0] v, int s);
    longint r;
    longint chunk;
    int n;
    n = OUT_W / s;
    r = 0;
    for (int k = 0; k < n; k++) begin
      chunk = (longint'(v) >> (k * s)) & ((longint'(1) << s) - 1);
      r = r | (chunk << ((n - 1 - k) * s));
    end
    return r[OUT_W-1:0];
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0;
    in_data  = 'x;
    flush    = 1'b0;
  endtask

  // Presents one word for a single cycle (COLLECT state accepts it).
  task automatic beat(input logic [IN_W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || out_partial !== 1'b0) begin
      $display("FAIL reset_state: valid=%b ready=%b data=%h partial=%b required 0 1 00 0",
               out_valid, in_ready, out_data, out_partial);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(4'hA);
    beat(4'h1);
    @(negedge clk);
    drive_idle();
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 8'h4A || out_partial !== 1'b0) begin
      $display("FAIL basic_slice2: valid=%b data=%h partial=%b required 1 4a 0",
               out_valid, out_data, out_partial);
    end else n_pass++;
    n_total++;
    if (s1_out_valid !== 1'b1 || s1_out_data !== 8'h85) begin
      $display("FAIL basic_slice1: valid=%b data=%h required 1 85", s1_out_valid, s1_out_data);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL basic_drain: out_valid=%b required 0", out_valid);
    end else n_pass++;
    $display("test_basic: A,1 -> %h", 8'h4A);
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    beat(4'hC);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 8'h03 || out_partial !== 1'b1) begin
      $display("FAIL flush_partial: valid=%b data=%h partial=%b required 1 03 1",
               out_valid, out_data, out_partial);
    end else n_pass++;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) begin
        $display("FAIL flush_empty: out_valid=%b required 0 (cycle %0d)", out_valid, i);
      end else n_pass++;
    end
    $display("test_flush: C + flush -> 03 partial");
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] held;
    out_ready = 1'b0;
    beat(4'h3);
    beat(4'h9);
    @(negedge clk);
    drive_idle();
    held = ref_rev(8'h39, 2);
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        $display("FAIL backpressure_hold: valid=%b data=%h in_ready=%b required 1 %h 0 (cycle %0d)",
                 out_valid, out_data, in_ready, held, i);
      end else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'h5;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL backpressure_release: in_ready=%b required 1", in_ready);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL backpressure_fire: out_valid=%b required 0", out_valid);
    end else n_pass++;
    in_data = 4'h1;
    @(negedge clk);
    drive_idle();
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 8'h45 || out_partial !== 1'b0) begin
      $display("FAIL back_to_back_group: valid=%b data=%h partial=%b required 1 45 0",
               out_valid, out_data, out_partial);
    end else n_pass++;
    @(negedge clk);
    $display("test_backpressure: held %h, then 5,1 -> 45", held);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    beat(4'h7);
    @(negedge clk);
    drive_idle();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    beat(4'h6);
    beat(4'h2);
    @(negedge clk);
    drive_idle();
    n_total++;
    if (out_valid !== 1'b1) begin
      $display("FAIL async_setup: out_valid=%b required 1", out_valid);
    end else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      $display("FAIL async_reset_drop: valid=%b data=%h required 0 00", out_valid, out_data);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    beat(4'hA);
    beat(4'h1);
    @(negedge clk);
    drive_idle();
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 8'h4A || out_partial !== 1'b0) begin
      $display("FAIL async_reset_recover: valid=%b data=%h partial=%b required 1 4a 0",
               out_valid, out_data, out_partial);
    end else n_pass++;
    @(negedge clk);
    $display("test_async_reset: recovered with 4a");
  endtask

  // Reference: a queue of words in the current group plus one pending output.
  task automatic test_random();
    logic [IN_W-1:0]  group[$];
    logic             pend;
    logic [OUT_W-1:0] exp_data;
    logic             exp_part;
    logic             exp_ready;
    logic [OUT_W-1:0] cat;
    int               n_out;
    do_reset();
    group.delete();
    pend  = 1'b0;
    n_out = 0;
    exp_data = '0;
    exp_part = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== pend) begin
        $display("FAIL random_valid: cycle %0d out_valid=%b required %b", cyc, out_valid, pend);
      end else n_pass++;
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = IN_W'($urandom);
      flush     = ($urandom_range(0, 99) < 12);
      out_ready = (cyc > 480) || ($urandom_range(0, 99) < 55);
      if (cyc > 480) in_valid = 1'b0;
      #1;
      exp_ready = !pend || out_ready;
      n_total++;
      if (in_ready !== exp_ready) begin
        $display("FAIL random_in_ready: cycle %0d in_ready=%b required %b", cyc, in_ready, exp_ready);
      end else n_pass++;
      if (pend) begin
        if (out_ready) begin
          n_total++;
          if (out_data !== exp_data || out_partial !== exp_part) begin
            $display("FAIL random_output: #%0d data=%h partial=%b required %h %b",
                     n_out, out_data, out_partial, exp_data, exp_part);
          end else n_pass++;
          $display("random out #%0d: data=%h partial=%b", n_out, out_data, out_partial);
          n_out++;
          pend = 1'b0;
          if (in_valid) group.push_back(in_data);
        end
      end else begin
        if (in_valid) group.push_back(in_data);
        if (group.size() == DEPTH || (flush && group.size() > 0)) begin
          exp_part = (group.size() != DEPTH);
          cat = '0;
          for (int i = 0; i < group.size(); i++)
            cat = cat | (OUT_W'(group[i]) << (OUT_W - IN_W * (i + 1)));
          exp_data = ref_rev(cat, 2);
          pend = 1'b1;
          group.delete();
        end
      end
    end
    drive_idle();
    n_total++;
    if (n_out < 20) begin
      $display("FAIL random_volume: outputs=%0d required >= 20", n_out);
    end else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    drive_idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_flush();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
